// File: rtl/instr_issue_queue.sv
// Purpose : FIFO-backed instruction feeder; holds each queued instruction on the CPU bus for its opcode-dependent length.
// Latency : a write is poppable from the next edge; an issued instruction appears one edge after the pop decision.
// Backpr. : o_wr_ready = !full (registered occupancy); a write is dropped when full. Optional macro ISSUE_STEP_EN adds i_step gating.
module instr_issue_queue #(
    parameter int                  DEPTH        = 8,
    parameter int                  INSTR_W      = 14,
    parameter logic [3:0]          SHORT_OPCODE = 4'd1,
    parameter int                  SHORT_CYCLES = 7,
    parameter int                  LONG_CYCLES  = 9,
    parameter logic [INSTR_W-1:0]  NOP_INSTR    = '0
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_wr_valid,
    output logic                         o_wr_ready,
    input  logic [INSTR_W-1:0]           i_wr_instr,
    input  logic                         i_run,
`ifdef ISSUE_STEP_EN
    input  logic                         i_step,
`endif
    output logic [INSTR_W-1:0]           o_instruction,
    output logic                         o_reg_val_or_pc,
    output logic                         o_issue_active,
    output logic                         o_issue_done,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_empty,
    output logic                         o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int MAX_C = (SHORT_CYCLES > LONG_CYCLES) ? SHORT_CYCLES : LONG_CYCLES;
    localparam int HC_W  = $clog2(MAX_C);

    typedef enum logic {IDLE, HOLD} state_t;

    logic [INSTR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    state_t             r_state;
    logic [HC_W-1:0]    r_hc;
    logic [INSTR_W-1:0] r_instruction;
    logic               r_issue_active;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_issue_ok;
    logic               w_slot_free;
    logic               w_pop;
    logic [INSTR_W-1:0] w_head;

    // Hold counter reload: last index of the hold window for this instruction.
    function automatic logic [HC_W-1:0] hold_last(input logic [INSTR_W-1:0] x);
        return (x[3:0] == SHORT_OPCODE) ? HC_W'(SHORT_CYCLES - 1) : HC_W'(LONG_CYCLES - 1);
    endfunction

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_push      = i_wr_valid && !w_full;
    assign w_head      = r_mem[r_rd_ptr];
`ifdef ISSUE_STEP_EN
    assign w_issue_ok  = i_run && i_step && !w_empty;
`else
    assign w_issue_ok  = i_run && !w_empty;
`endif
    // A new instruction may be loaded when idle or in the final cycle of the current hold.
    assign w_slot_free = (r_state == IDLE) || (r_hc == '0);
    assign w_pop       = w_issue_ok && w_slot_free;

    // Storage array: written on an accepted write, no reset needed.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_instr;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Issue FSM: load head on pop, count down the hold, return to NOP when nothing follows.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_hc           <= '0;
            r_instruction  <= NOP_INSTR;
            r_issue_active <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_instruction  <= w_head;
                        r_hc           <= hold_last(w_head);
                        r_issue_active <= 1'b1;
                        r_state        <= HOLD;
                    end else begin
                        r_instruction  <= NOP_INSTR;
                        r_issue_active <= 1'b0;
                    end
                end
                HOLD: begin
                    if (r_hc != '0) begin
                        r_hc <= r_hc - HC_W'(1);
                    end else if (w_pop) begin
                        r_instruction  <= w_head;
                        r_hc           <= hold_last(w_head);
                        r_issue_active <= 1'b1;
                    end else begin
                        r_instruction  <= NOP_INSTR;
                        r_issue_active <= 1'b0;
                        r_state        <= IDLE;
                    end
                end
                default: begin
                    r_state        <= IDLE;
                    r_instruction  <= NOP_INSTR;
                    r_issue_active <= 1'b0;
                end
            endcase
        end
    end

    assign o_wr_ready      = !w_full;
    assign o_full          = w_full;
    assign o_empty         = w_empty;
    assign o_count         = r_count;
    assign o_instruction   = r_instruction;
    assign o_issue_active  = r_issue_active;
    assign o_issue_done    = (r_state == HOLD) && (r_hc == '0);
    assign o_reg_val_or_pc = 1'b0;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations on hold lengths and flags.
// Build with ISSUE_STEP_EN defined to also exercise single-step gating.
module tb_instr_issue_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    logic [13:0] wr_instr = '0;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        wr_ready;
    logic [13:0] instruction;
    logic        reg_val_or_pc;
    logic        issue_active;
    logic        issue_done;
    logic [3:0]  count;
    logic        empty;
    logic        full;

    instr_issue_queue dut (
        .i_clock        (clk),
        .i_reset        (reset),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_instr     (wr_instr),
        .i_run          (run),
`ifdef ISSUE_STEP_EN
        .i_step         (step),
`endif
        .o_instruction  (instruction),
        .o_reg_val_or_pc(reg_val_or_pc),
        .o_issue_active (issue_active),
        .o_issue_done   (issue_done),
        .o_count        (count),
        .o_empty        (empty),
        .o_full         (full)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int mark   = 0;
    int done_log[$];
    int vis_n  = 0;
    logic [13:0] watch = 14'h3FFF;
    bit  chk_en = 1'b0;

    // Reference model: pending queue, current instruction and cycles remaining in its hold.
    int q[$];
    int cur = 0;
    int rem = 0;
    int sz;
    bit pop_ok;
    bit step_ok;

    function automatic int hold_len(input int x);
        return ((x & 15) == 1) ? 7 : 9;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            rem = 0;
            cur = 0;
        end else begin
            sz = q.size();
`ifdef ISSUE_STEP_EN
            step_ok = step;
`else
            step_ok = 1'b1;
`endif
            pop_ok = run && step_ok && (sz > 0) && (rem <= 1);
            if (pop_ok) begin
                cur = q.pop_front();
                rem = hold_len(cur);
            end else if (rem > 0) begin
                rem--;
            end
            if (wr_valid && sz < 8) q.push_back(int'(wr_instr));
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("instruction",   int'(instruction),   (rem > 0) ? cur : 0);
            chk("issue_active",  int'(issue_active),  (rem > 0) ? 1 : 0);
            chk("issue_done",    int'(issue_done),    (rem == 1) ? 1 : 0);
            chk("count",         int'(count),         q.size());
            chk("empty",         int'(empty),         (q.size() == 0) ? 1 : 0);
            chk("full",          int'(full),          (q.size() == 8) ? 1 : 0);
            chk("wr_ready",      int'(wr_ready),      (q.size() < 8) ? 1 : 0);
            chk("reg_val_or_pc", int'(reg_val_or_pc), 0);
            if (issue_done) done_log.push_back(cyc - mark);
            if (instruction == watch) vis_n++;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic write(input logic [13:0] v);
        wr_valid = 1'b1;
        wr_instr = v;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic start_run();
        done_log.delete();
        mark = cyc;
        run = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        // Reset state literals
        chk("rst_instruction", int'(instruction), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_wr_ready", int'(wr_ready), 1);
        chk("rst_active", int'(issue_active), 0);
        reset = 1'b0;

        // 1) single short instruction
        write(14'h2A1);
        watch = 14'h2A1;
        vis_n = 0;
        start_run();
        tick();
        chk("t1_first", int'(instruction), 14'h2A1);
        repeat (9) tick();
        chk("t1_visible", vis_n, 7);
        chk("t1_npulse", done_log.size(), 1);
        if (done_log.size() >= 1) chk("t1_done_at", done_log[0], 7);
        chk("t1_nop", int'(instruction), 0);
        chk("t1_inactive", int'(issue_active), 0);
        chk("t1_empty", int'(empty), 1);
        run = 1'b0;
        watch = 14'h3FFF;

        // 2) back-to-back 9,7,9
        do_reset();
        write(14'h0002);
        write(14'h0011);
        write(14'h0003);
        start_run();
        repeat (27) tick();
        chk("t2_npulse", done_log.size(), 3);
        if (done_log.size() >= 3) begin
            chk("t2_done0", done_log[0], 9);
            chk("t2_done1", done_log[1], 16);
            chk("t2_done2", done_log[2], 25);
        end
        run = 1'b0;

        // 3) fill, overflow attempt, write+pop on same edge
        do_reset();
        for (int i = 0; i < 9; i++) write({i[9:0], 4'h2});
        chk("t3_count", int'(count), 8);
        chk("t3_full", int'(full), 1);
        chk("t3_wr_ready", int'(wr_ready), 0);
        start_run();
        repeat (18) tick();
        chk("t3_before", int'(count), 6);
        wr_valid = 1'b1;
        wr_instr = 14'h155;
        tick();
        wr_valid = 1'b0;
        chk("t3_after", int'(count), 6);
        chk("t3_third", int'(instruction), 14'h022);
        run = 1'b0;

        // 4) reset during hold cycle 4
        do_reset();
        write(14'h0005);
        write(14'h0006);
        start_run();
        repeat (4) tick();
        chk("t4_holding", int'(instruction), 14'h0005);
        reset = 1'b1;
        tick();
        chk("t4_nop", int'(instruction), 0);
        chk("t4_count", int'(count), 0);
        chk("t4_inactive", int'(issue_active), 0);
        reset = 1'b0;
        repeat (12) tick();
        chk("t4_nopulse", done_log.size(), 0);
        run = 1'b0;

        // 5) run dropped mid-hold
        do_reset();
        write(14'h0102);
        write(14'h0013);
        write(14'h0204);
        start_run();
        repeat (3) tick();
        run = 1'b0;
        repeat (9) tick();
        chk("t5_count", int'(count), 2);
        chk("t5_nop", int'(instruction), 0);
        chk("t5_inactive", int'(issue_active), 0);
        chk("t5_npulse", done_log.size(), 1);
        if (done_log.size() >= 1) chk("t5_done_at", done_log[0], 9);
        run = 1'b1;
        tick();
        chk("t5_resume", int'(instruction), 14'h0013);
        repeat (20) tick();
        chk("t5_drained", int'(empty), 1);
        run = 1'b0;

`ifdef ISSUE_STEP_EN
        // 6) single step
        do_reset();
        write(14'h0042);
        write(14'h0052);
        start_run();
        repeat (3) tick();
        chk("t6_gated", int'(count), 2);
        step = 1'b1;
        tick();
        step = 1'b0;
        repeat (12) tick();
        chk("t6_count", int'(count), 1);
        chk("t6_inactive", int'(issue_active), 0);
        chk("t6_npulse", done_log.size(), 1);
        run = 1'b0;
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
